muxn_rr_reg: RTL

Parametrised N-input, width-W registered multiplexer with per-channel valid/ready handshakes and round-robin selection. It replaces the fixed 2:1, 32-bit combinational select wherever several register-file or datapath sources compete for one sink. It adds a one-entry output register with backpressure, so a source is consumed only when its word is captured. It reports which channel each output word came from.

---
 rtl/muxn_rr_reg_if.sv | 26 ++
 rtl/muxn_rr_reg.sv | 78 +++++++
 2 files changed

// File: rtl/muxn_rr_reg_if.sv
// Handshake bundle for muxn_rr_reg: N packed input channels plus one registered output.
// Master drives sources and sink-ready; slave is the mux.
interface muxn_rr_reg_if #(
  parameter int width = 32,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [N*width-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [width-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/muxn_rr_reg.sv
// N-input round-robin mux into a one-entry output register; 1-cycle latency, 1 word/cycle.
// A source is consumed only when its word is captured; a held, unread word drops all in_ready.
module muxn_rr_reg #(
  parameter int  width = 32,
  parameter int  N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RESET,
  muxn_rr_reg_if.slave bus
);
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    r_sel;
  logic [width-1:0] r_data;
  logic             r_valid;

  logic             w_can_load;
  logic             w_any_vld;
  logic             w_hi_vld;
  logic             w_accept;
  logic [SW-1:0]    w_hi_gnt;
  logic [SW-1:0]    w_lo_gnt;
  logic [SW-1:0]    w_gnt;
  logic [SW-1:0]    w_ptr_nxt;
  logic [width-1:0] w_gnt_data;

  // Lowest valid index at or above ptr wins; if none, wrap to the lowest valid index overall.
  always_comb begin
    w_any_vld = 1'b0;
    w_lo_gnt  = '0;
    w_hi_vld  = 1'b0;
    w_hi_gnt  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_any_vld = 1'b1;
        w_lo_gnt  = SW'(i);
        if (SW'(i) >= r_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_gnt = SW'(i);
        end
      end
    end
  end

  assign w_gnt      = w_hi_vld ? w_hi_gnt : w_lo_gnt;
  assign w_can_load = ~r_valid | bus.out_ready;
  assign w_accept   = w_can_load & w_any_vld & ~RESET;
  assign w_gnt_data = bus.in_data[int'(w_gnt)*width +: width];
  assign w_ptr_nxt  = (w_gnt == SW'(N - 1)) ? '0 : w_gnt + SW'(1);

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = w_accept & (w_gnt == SW'(i));
    end
  end

  // A new word may overwrite one being drained in the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt;
      r_ptr   <= w_ptr_nxt;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_valid = r_valid;
endmodule
